controller_player: RTL and testbench

// - Scripted, multi-pad NES controller emulator. Generalises the single-pad controller_sim.
// - Serves NUM_PADS standard pads on the $4016/$4017 serial protocol (strobe, rd, data).
// - Button states change at programmed timestamps, loaded from a script FIFO. Per-pad turbo on A/B.
// - Sits in the nes_tb / board top between the NES controller port pins and a host or script source.
// - Replaces hard-coded cycle-based button always_comb blocks.

---
 rtl/controller_player.sv | 149 ++++++++++++++
 tb/tb_controller_player.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/controller_player.sv
// Scripted multi-pad NES controller emulator: timestamped button script FIFO,
// per-pad A/B turbo and the $4016/$4017 strobe/read serial protocol.
module controller_player #(
    parameter int   NUM_PADS     = 2,
    parameter int   SCRIPT_DEPTH = 16,
    parameter int   TS_W         = 24,
    parameter int   TURBO_PERIOD = 2,
    parameter logic FILL_BIT     = 1'b1,
    localparam int  PAD_W        = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tick,
    input  logic                  strobe,
    input  logic [NUM_PADS-1:0]   rd,
    output logic [NUM_PADS-1:0]   data,
    input  logic                  scr_valid,
    output logic                  scr_ready,
    input  logic [TS_W-1:0]       scr_time,
    input  logic [PAD_W-1:0]      scr_pad,
    input  logic [7:0]            scr_btns,
    input  logic [2*NUM_PADS-1:0] turbo_mask,
    output logic [8*NUM_PADS-1:0] btns_cur,
    output logic [TS_W-1:0]       time_now,
    output logic                  script_empty,
    output logic                  order_err
);

    localparam int AW   = $clog2(SCRIPT_DEPTH);
    localparam int TC_W = $clog2(TURBO_PERIOD + 1);
    localparam logic [AW:0]     PTR_ONE = 1;
    localparam logic [TS_W-1:0] TS_ONE  = 1;
    localparam logic [TC_W-1:0] TC_ONE  = 1;
    localparam logic [TC_W-1:0] TC_LAST = TC_W'(TURBO_PERIOD - 1);

    logic [TS_W-1:0]  fifo_time [SCRIPT_DEPTH];
    logic [PAD_W-1:0] fifo_pad  [SCRIPT_DEPTH];
    logic [7:0]       fifo_btns [SCRIPT_DEPTH];

    logic [TS_W-1:0] time_q, time_d;
    logic [TS_W-1:0] last_time_q, last_time_d;
    logic [AW:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic            order_err_q, order_err_d;
    logic [TC_W-1:0] tcnt_q, tcnt_d;
    logic            phase_q, phase_d;
    logic            strobe_q;
    logic [NUM_PADS-1:0] rd_q;
    logic [7:0]      btns_q [NUM_PADS];
    logic [7:0]      btns_d [NUM_PADS];
    logic [7:0]      sr_q   [NUM_PADS];
    logic [7:0]      sr_d   [NUM_PADS];

    logic            full, empty, push, pop;
    logic [AW-1:0]   wr_idx, rd_idx;
    logic [TS_W-1:0] head_time;
    logic [PAD_W-1:0] head_pad;
    logic [7:0]      head_btns;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign wr_idx    = wr_ptr_q[AW-1:0];
    assign rd_idx    = rd_ptr_q[AW-1:0];
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign head_time = fifo_time[rd_idx];
    assign head_pad  = fifo_pad[rd_idx];
    assign head_btns = fifo_btns[rd_idx];
    assign push      = scr_valid & ~full;
    assign pop       = ~empty & (time_q >= head_time);

    always_comb begin
        time_d      = tick ? time_q + TS_ONE : time_q;
        wr_ptr_d    = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d    = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        last_time_d = push ? scr_time : last_time_q;
        order_err_d = order_err_q | (push & (scr_time < last_time_q));
        tcnt_d      = tcnt_q;
        phase_d     = phase_q;
        if (strobe_q && !strobe) begin
            if (tcnt_q == TC_LAST) begin
                tcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                tcnt_d = tcnt_q + TC_ONE;
            end
        end
        // Out-of-range pad indices match no pad, so such entries are simply dropped.
        for (int p = 0; p < NUM_PADS; p++) begin
            btns_d[p] = btns_q[p];
            if (pop && head_pad == PAD_W'(p)) btns_d[p] = head_btns;
            sr_d[p] = sr_q[p];
            if (strobe) begin
                sr_d[p] = btns_q[p] & ~({6'b0, turbo_mask[2*p +: 2]} & {8{phase_q}});
            end else if (rd_q[p] && !rd[p]) begin
                sr_d[p] = {FILL_BIT, sr_q[p][7:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            time_q      <= '0;
            last_time_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            order_err_q <= 1'b0;
            tcnt_q      <= '0;
            phase_q     <= 1'b0;
            strobe_q    <= 1'b0;
            rd_q        <= '0;
            for (int p = 0; p < NUM_PADS; p++) begin
                btns_q[p] <= 8'h00;
                sr_q[p]   <= 8'h00;
            end
        end else begin
            time_q      <= time_d;
            last_time_q <= last_time_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            order_err_q <= order_err_d;
            tcnt_q      <= tcnt_d;
            phase_q     <= phase_d;
            strobe_q    <= strobe;
            rd_q        <= rd;
            for (int p = 0; p < NUM_PADS; p++) begin
                btns_q[p] <= btns_d[p];
                sr_q[p]   <= sr_d[p];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            fifo_time[wr_idx] <= scr_time;
            fifo_pad[wr_idx]  <= scr_pad;
            fifo_btns[wr_idx] <= scr_btns;
        end
    end

    for (genvar g = 0; g < NUM_PADS; g++) begin : g_pad
        assign data[g]            = sr_q[g][0];
        assign btns_cur[8*g +: 8] = btns_q[g];
    end

    assign scr_ready    = ~full;
    assign script_empty = empty;
    assign time_now     = time_q;
    assign order_err    = order_err_q;

endmodule

// File: tb/tb_controller_player.sv
// Self-checking bench for controller_player: directed scenarios against fixed
// expectations plus randomized traffic against a queue-based behavioural model.
module tb_controller_player;

    localparam int TMOD  = 1024;
    localparam int TP    = 2;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0;
    logic        strobe = 1'b0;
    logic [1:0]  rd = 2'b00;
    logic [1:0]  data;
    logic        scr_valid = 1'b0;
    logic        scr_ready;
    logic [9:0]  scr_time = '0;
    logic        scr_pad = 1'b0;
    logic [7:0]  scr_btns = '0;
    logic [3:0]  turbo_mask = '0;
    logic [15:0] btns_cur;
    logic [9:0]  time_now;
    logic        script_empty;
    logic        order_err;

    int nCompared = 0;
    int nMismatched = 0;

    typedef struct {
        int         t;
        int         pad;
        logic [7:0] b;
    } entry_t;

    // Model: script queue, per-pad latched byte plus a count of bits already read.
    entry_t     mq[$];
    int         mtime = 0;
    int         mlast = 0;
    bit         morder = 0;
    int         mfalls = 0;
    logic       mstrobePrev = 0;
    logic [1:0] mrdPrev = 0;
    logic [7:0] mbtns [2];
    logic [7:0] mlat [2];
    int         mcnt [2];

    controller_player #(
        .NUM_PADS(2), .SCRIPT_DEPTH(DEPTH), .TS_W(10), .TURBO_PERIOD(TP), .FILL_BIT(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .strobe(strobe), .rd(rd), .data(data),
        .scr_valid(scr_valid), .scr_ready(scr_ready), .scr_time(scr_time),
        .scr_pad(scr_pad), .scr_btns(scr_btns), .turbo_mask(turbo_mask),
        .btns_cur(btns_cur), .time_now(time_now), .script_empty(script_empty),
        .order_err(order_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        logic [7:0] eff [2];
        bit         doPop, doPush;
        bit         phase;
        entry_t     e;
        if (!rst_n) begin
            mq.delete();
            mtime = 0; mlast = 0; morder = 0; mfalls = 0;
            mstrobePrev = 0; mrdPrev = 0;
            for (int p = 0; p < 2; p++) begin
                mbtns[p] = 0; mlat[p] = 0; mcnt[p] = 0;
            end
        end else begin
            phase = ((mfalls / TP) % 2) == 1;
            for (int p = 0; p < 2; p++) begin
                eff[p] = mbtns[p];
                if (phase && turbo_mask[2*p]) eff[p][0] = 1'b0;
                if (phase && turbo_mask[2*p+1]) eff[p][1] = 1'b0;
            end
            doPop  = (mq.size() > 0) && (mtime >= mq[0].t);
            doPush = scr_valid && (mq.size() < DEPTH);
            if (doPop) begin
                e = mq.pop_front();
                if (e.pad < 2) mbtns[e.pad] = e.b;
            end
            if (doPush) begin
                if (int'(scr_time) < mlast) morder = 1;
                mlast = int'(scr_time);
                e.t = int'(scr_time); e.pad = int'(scr_pad); e.b = scr_btns;
                mq.push_back(e);
            end
            if (mstrobePrev && !strobe) mfalls++;
            for (int p = 0; p < 2; p++) begin
                if (strobe) begin
                    mlat[p] = eff[p];
                    mcnt[p] = 0;
                end else if (mrdPrev[p] && !rd[p] && mcnt[p] < 8) begin
                    mcnt[p]++;
                end
            end
            mstrobePrev = strobe;
            mrdPrev = rd;
            if (tick) mtime = (mtime + 1) % TMOD;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        tick = 0; strobe = 0; rd = 2'b00; scr_valid = 0; turbo_mask = '0;
    endtask

    task automatic doReset();
        rst_n = 0;
        idleInputs();
        step();
        step();
        rst_n = 1;
    endtask

    task automatic pushEntry(input int t, input int pad, input logic [7:0] b);
        scr_valid = 1; scr_time = 10'(t); scr_pad = pad[0]; scr_btns = b;
        step();
        scr_valid = 0;
    endtask

    task automatic test_reset();
        idleInputs();
        rst_n = 0; scr_valid = 1; scr_time = 10'd3; scr_btns = 8'hFF; tick = 1; strobe = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            nCompared++;
            if ({data, btns_cur, time_now, script_empty, scr_ready} !== {2'b00, 16'h0000, 10'd0, 1'b1, 1'b1}) begin
                nMismatched++;
                $display("[TB] FAIL reset_state cycle %0d: got data=%b btns=%h time=%0d empty=%b ready=%b, expected 00/0000/0/1/1",
                         i, data, btns_cur, time_now, script_empty, scr_ready);
            end
        end
        idleInputs();
        rst_n = 1;
        step();
        step();
        nCompared++;
        if (script_empty !== 1'b1 || order_err !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL reset_fifo_empty: got empty=%b order_err=%b, expected 1/0", script_empty, order_err);
        end
    endtask

    task automatic test_serial();
        logic [9:0] expA = 10'b1100001001;
        doReset();
        pushEntry(0, 0, 8'h09);
        step();
        step();
        nCompared++;
        if (btns_cur !== 16'h0009) begin
            nMismatched++;
            $display("[TB] FAIL serial_btns: got %h expected 0009", btns_cur);
        end
        strobe = 1; step();
        strobe = 0; step();
        for (int i = 0; i < 10; i++) begin
            nCompared++;
            if (data !== {(i >= 8) ? 1'b1 : 1'b0, expA[i]}) begin
                nMismatched++;
                $display("[TB] FAIL serial_read %0d: got %b expected %b", i, data,
                         {(i >= 8) ? 1'b1 : 1'b0, expA[i]});
            end
            rd = 2'b11; step();
            rd = 2'b00; step();
        end
    endtask

    task automatic test_timing();
        doReset();
        pushEntry(100, 1, 8'h80);
        tick = 1;
        for (int cnt = 1; cnt <= 104; cnt++) begin
            step();
            nCompared++;
            if (time_now !== 10'(cnt) || btns_cur !== ((cnt >= 101) ? 16'h8000 : 16'h0000)) begin
                nMismatched++;
                $display("[TB] FAIL timing at %0d: got time=%0d btns=%h expected time=%0d btns=%h",
                         cnt, time_now, btns_cur, cnt, (cnt >= 101) ? 16'h8000 : 16'h0000);
            end
        end
        tick = 0;
    endtask

    task automatic test_fifo();
        doReset();
        for (int k = 0; k < DEPTH; k++) begin
            nCompared++;
            if (scr_ready !== 1'b1) begin
                nMismatched++;
                $display("[TB] FAIL fifo_ready before push %0d: got %b expected 1", k, scr_ready);
            end
            pushEntry(1000, 0, 8'(k + 1));
        end
        nCompared++;
        if (scr_ready !== 1'b0 || script_empty !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL fifo_full: got ready=%b empty=%b expected 0/0", scr_ready, script_empty);
        end
        pushEntry(1000, 0, 8'hFF);
        tick = 1;
        for (int i = 0; i < 1000; i++) step();
        tick = 0;
        nCompared++;
        if (time_now !== 10'd1000 || btns_cur !== 16'h0000 || scr_ready !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL fifo_wait: got time=%0d btns=%h ready=%b expected 1000/0000/0",
                     time_now, btns_cur, scr_ready);
        end
        for (int k = 0; k < DEPTH; k++) begin
            if (k == 0) begin
                scr_valid = 1; scr_time = 10'd1000; scr_pad = 0; scr_btns = 8'hAA;
            end
            step();
            scr_valid = 0;
            nCompared++;
            if (btns_cur !== {8'h00, 8'(k + 1)} || script_empty !== (k == DEPTH - 1) || scr_ready !== 1'b1) begin
                nMismatched++;
                $display("[TB] FAIL fifo_pop %0d: got btns=%h empty=%b ready=%b expected %h/%b/1",
                         k, btns_cur, script_empty, scr_ready, {8'h00, 8'(k + 1)}, (k == DEPTH - 1));
            end
        end
        step();
        nCompared++;
        if (btns_cur !== 16'h0010 || script_empty !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL fifo_last_wins: got btns=%h empty=%b expected 0010/1", btns_cur, script_empty);
        end
    endtask

    task automatic test_turbo();
        logic [5:0] expT = 6'b110011;
        doReset();
        pushEntry(0, 0, 8'h01);
        step();
        step();
        turbo_mask = 4'b0001;
        for (int k = 0; k < 6; k++) begin
            strobe = 1; step();
            strobe = 0; step();
            nCompared++;
            if (data !== {1'b0, expT[k]}) begin
                nMismatched++;
                $display("[TB] FAIL turbo latch %0d: got %b expected %b", k, data, {1'b0, expT[k]});
            end
        end
        turbo_mask = '0;
    endtask

    task automatic test_order_wrap();
        doReset();
        pushEntry(50, 0, 8'h11);
        nCompared++;
        if (order_err !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL order_first: got %b expected 0", order_err);
        end
        pushEntry(20, 1, 8'h22);
        nCompared++;
        if (order_err !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL order_second: got %b expected 1", order_err);
        end
        tick = 1;
        for (int cnt = 1; cnt <= TMOD; cnt++) begin
            step();
            nCompared++;
            if (time_now !== 10'(cnt % TMOD) ||
                btns_cur !== {(cnt >= 52) ? 8'h22 : 8'h00, (cnt >= 51) ? 8'h11 : 8'h00}) begin
                nMismatched++;
                $display("[TB] FAIL order_wrap at %0d: got time=%0d btns=%h expected time=%0d btns=%h",
                         cnt, time_now, btns_cur, cnt % TMOD,
                         {(cnt >= 52) ? 8'h22 : 8'h00, (cnt >= 51) ? 8'h11 : 8'h00});
            end
        end
        tick = 0;
        nCompared++;
        if (order_err !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL order_sticky: got %b expected 1", order_err);
        end
    endtask

    task automatic test_random();
        logic [1:0] expData;
        doReset();
        for (int i = 0; i < 3000; i++) begin
            rst_n      = !(i >= 1500 && i < 1502);
            tick       = 1'($urandom_range(0, 1));
            scr_valid  = ($urandom_range(0, 3) == 0);
            scr_time   = 10'((mtime + $urandom_range(0, 40) + TMOD - 8) % TMOD);
            scr_pad    = 1'($urandom_range(0, 1));
            scr_btns   = 8'($urandom);
            if ($urandom_range(0, 7) == 0) strobe = ~strobe;
            rd         = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) turbo_mask = 4'($urandom);
            step();
            for (int p = 0; p < 2; p++) expData[p] = (mcnt[p] >= 8) ? 1'b1 : mlat[p][mcnt[p]];
            nCompared++;
            if (data !== expData) begin
                nMismatched++;
                $display("[TB] FAIL rand_data cycle %0d: got %b expected %b", i, data, expData);
            end
            nCompared++;
            if (btns_cur !== {mbtns[1], mbtns[0]} || time_now !== 10'(mtime)) begin
                nMismatched++;
                $display("[TB] FAIL rand_state cycle %0d: got btns=%h time=%0d expected btns=%h time=%0d",
                         i, btns_cur, time_now, {mbtns[1], mbtns[0]}, mtime);
            end
            nCompared++;
            if ({script_empty, scr_ready, order_err} !== {mq.size() == 0, mq.size() < DEPTH, morder}) begin
                nMismatched++;
                $display("[TB] FAIL rand_flags cycle %0d: got empty/ready/err=%b%b%b expected %b%b%b",
                         i, script_empty, scr_ready, order_err, mq.size() == 0, mq.size() < DEPTH, morder);
            end
        end
        rst_n = 1;
        idleInputs();
    endtask

    initial begin
        test_reset();
        test_serial();
        test_timing();
        test_fifo();
        test_turbo();
        test_order_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
